// File: rtl/cam_gray_writer_pkg.sv
// Shared definitions for the grayscale frame writer: FSM states, luma
// weights, RGB565 field positions and the channel widening helpers.
package cam_gray_writer_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACTIVE = 2'd1,
        ST_FLUSH  = 2'd2,
        ST_SKIP   = 2'd3
    } state_t;

    // BT.601-style luma weights scaled by 256
    localparam int COEF_R = 77;
    localparam int COEF_G = 150;
    localparam int COEF_B = 29;

    // Bit offsets of the channels inside an RGB565 word
    localparam int R_LSB = 11;
    localparam int G_LSB = 5;
    localparam int B_LSB = 0;

    // Widen a 5-bit channel by replicating its top bits into the LSBs
    function automatic logic [7:0] expand5(input logic [4:0] v);
        return {v, v[4:2]};
    endfunction

    // Widen a 6-bit channel by replicating its top bits into the LSBs
    function automatic logic [7:0] expand6(input logic [5:0] v);
        return {v, v[5:4]};
    endfunction

endpackage

// File: rtl/cam_gray_writer_if.sv
// Pixel-in / frame-buffer-out / SoC handshake bundle of the gray writer.
// slave is the writer side, master is the camera/SoC/memory side.
interface cam_gray_writer_if #(
    parameter int ADDR_W = 18
);
    logic [15:0]       px_data;
    logic              px_valid;
    logic              frame_start;
    logic              line_end;
    logic              buf_release;
    logic              release_bank;
    logic [ADDR_W-1:0] mem_addr;
    logic [7:0]        mem_data;
    logic              mem_we;
    logic              frame_ready;
    logic              ready_bank;
    logic [1:0]        bank_full;
    logic              err_line;
    logic              err_short;
    logic [7:0]        drop_count;

    modport slave (
        input  px_data, px_valid, frame_start, line_end, buf_release, release_bank,
        output mem_addr, mem_data, mem_we, frame_ready, ready_bank, bank_full,
               err_line, err_short, drop_count
    );

    modport master (
        output px_data, px_valid, frame_start, line_end, buf_release, release_bank,
        input  mem_addr, mem_data, mem_we, frame_ready, ready_bank, bank_full,
               err_line, err_short, drop_count
    );
endinterface

// File: rtl/cam_gray_writer_rgb565_to_gray.sv
// Two-stage RGB565 -> 8-bit luma pipeline; valid and write address ride
// alongside the data so the outputs can drive the frame buffer directly.
module rgb565_to_gray
    import cam_gray_writer_pkg::*;
#(
    parameter int AW = 18
) (
    input  logic          pclk,
    input  logic          rst,
    input  logic          in_valid,
    input  logic [15:0]   in_data,
    input  logic [AW-1:0] in_addr,
    output logic          out_valid,
    output logic [7:0]    out_data,
    output logic [AW-1:0] out_addr
);
    logic [7:0]    r8;
    logic [7:0]    g8;
    logic [7:0]    b8;
    logic [15:0]   p_r;
    logic [15:0]   p_g;
    logic [15:0]   p_b;
    logic          s1_valid;
    logic [AW-1:0] s1_addr;

    assign r8 = expand5(in_data[R_LSB +: 5]);
    assign g8 = expand6(in_data[G_LSB +: 6]);
    assign b8 = expand5(in_data[B_LSB +: 5]);

    // Stage 1: weighted channel products (each fits 16 bits)
    always_ff @(posedge pclk or posedge rst) begin
        if (rst) begin
            s1_valid <= 1'b0;
            s1_addr  <= '0;
            p_r      <= '0;
            p_g      <= '0;
            p_b      <= '0;
        end else begin
            s1_valid <= in_valid;
            s1_addr  <= in_addr;
            p_r      <= 16'(COEF_R) * 16'(r8);
            p_g      <= 16'(COEF_G) * 16'(g8);
            p_b      <= 16'(COEF_B) * 16'(b8);
        end
    end

    // Stage 2: sum (max 65280, no overflow) and keep the integer part
    always_ff @(posedge pclk or posedge rst) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_addr  <= '0;
            out_data  <= '0;
        end else begin
            out_valid <= s1_valid;
            out_addr  <= s1_addr;
            out_data  <= 8'((p_r + p_g + p_b) >> 8);
        end
    end
endmodule

// File: rtl/cam_gray_writer.sv
// Camera pixel consumer: tracks frame/line position, feeds the luma
// pipeline, writes into a two-bank frame buffer and hands full banks to
// the SoC, dropping frames while both banks are owned by the SoC.
module cam_gray_writer
    import cam_gray_writer_pkg::*;
#(
    parameter int WIDTH  = 320,
    parameter int HEIGHT = 240,
    parameter int ADDR_W = 18
) (
    input  logic             pclk,
    input  logic             rst,
    cam_gray_writer_if.slave bus
);
    // x can run one past WIDTH so an over-long line is still detectable
    localparam int XW = $clog2(WIDTH + 2);
    localparam int YW = $clog2(HEIGHT + 1);
    localparam int OW = ADDR_W - 1;

    state_t            state;
    logic [XW-1:0]     x;
    logic [YW-1:0]     y;
    logic              bank;
    logic              flush_cnt;
    logic [1:0]        bank_full;
    logic              frame_ready;
    logic              ready_bank;
    logic              err_line;
    logic              err_short;
    logic [7:0]        drop_count;
    logic              in_valid;
    logic [15:0]       in_data;
    logic [ADDR_W-1:0] in_addr;

    logic [1:0]        release_mask;
    logic [1:0]        eff_full;
    logic              accept;
    logic [OW-1:0]     lin;

    // A release in the same cycle is applied before any bank choice
    assign release_mask = bus.buf_release ? (2'b01 << bus.release_bank) : 2'b00;
    assign eff_full     = bank_full & ~release_mask;
    assign accept       = (state == ST_ACTIVE) && bus.px_valid && !bus.frame_start
                          && (x < XW'(WIDTH));
    assign lin          = OW'(y) * OW'(WIDTH) + OW'(x);

    assign bus.bank_full   = bank_full;
    assign bus.frame_ready = frame_ready;
    assign bus.ready_bank  = ready_bank;
    assign bus.err_line    = err_line;
    assign bus.err_short   = err_short;
    assign bus.drop_count  = drop_count;

    // Frame/line tracking, bank ownership and pipeline entry register
    always_ff @(posedge pclk or posedge rst) begin
        if (rst) begin
            state       <= ST_IDLE;
            x           <= '0;
            y           <= '0;
            bank        <= 1'b0;
            flush_cnt   <= 1'b0;
            bank_full   <= 2'b00;
            frame_ready <= 1'b0;
            ready_bank  <= 1'b0;
            err_line    <= 1'b0;
            err_short   <= 1'b0;
            drop_count  <= 8'd0;
            in_valid    <= 1'b0;
            in_data     <= '0;
            in_addr     <= '0;
        end else begin
            frame_ready <= 1'b0;
            err_line    <= 1'b0;
            err_short   <= 1'b0;
            bank_full   <= eff_full;
            in_valid    <= accept;
            if (accept) begin
                in_data <= bus.px_data;
                in_addr <= {bank, lin};
            end
            case (state)
                ST_IDLE, ST_SKIP: begin
                    if (bus.frame_start) begin
                        if (eff_full != 2'b11) begin
                            state <= ST_ACTIVE;
                            bank  <= eff_full[0];
                            x     <= '0;
                            y     <= '0;
                        end else begin
                            state <= ST_SKIP;
                            if (drop_count != 8'hFF)
                                drop_count <= drop_count + 8'd1;
                        end
                    end
                end
                ST_ACTIVE: begin
                    if (bus.frame_start) begin
                        err_short <= 1'b1;
                        x         <= '0;
                        y         <= '0;
                    end else if (bus.line_end) begin
                        err_line <= (x != XW'(WIDTH));
                        x        <= '0;
                        y        <= y + YW'(1);
                        if (y == YW'(HEIGHT - 1)) begin
                            state     <= ST_FLUSH;
                            flush_cnt <= 1'b0;
                        end
                    end else if (bus.px_valid && (x != XW'(WIDTH + 1))) begin
                        x <= x + XW'(1);
                    end
                end
                ST_FLUSH: begin
                    if (flush_cnt) begin
                        bank_full   <= eff_full | (2'b01 << bank);
                        frame_ready <= 1'b1;
                        ready_bank  <= bank;
                        state       <= ST_IDLE;
                    end else begin
                        flush_cnt <= 1'b1;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    rgb565_to_gray #(
        .AW (ADDR_W)
    ) u_gray (
        .pclk      (pclk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_addr   (in_addr),
        .out_valid (bus.mem_we),
        .out_data  (bus.mem_data),
        .out_addr  (bus.mem_addr)
    );
endmodule

// File: tb/tb_cam_gray_writer.sv
// Directed bench for cam_gray_writer on a 4x2 frame with hand-computed
// luma values, bank hand-off, frame dropping, line/frame errors and reset.
module tb_cam_gray_writer;
    localparam int WIDTH  = 4;
    localparam int HEIGHT = 2;
    localparam int ADDR_W = 18;
    localparam int BANK1  = 1 << (ADDR_W - 1);

    logic pclk = 1'b0;
    logic rst  = 1'b1;

    cam_gray_writer_if #(.ADDR_W(ADDR_W)) bus();

    cam_gray_writer #(
        .WIDTH  (WIDTH),
        .HEIGHT (HEIGHT),
        .ADDR_W (ADDR_W)
    ) dut (
        .pclk (pclk),
        .rst  (rst),
        .bus  (bus)
    );

    always #5 pclk = ~pclk;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc_cnt  = 0;
    int wr_addr[$];
    int wr_data[$];
    int wr_cyc[$];
    int fr_bank[$];
    int fr_cyc[$];
    int err_line_n  = 0;
    int err_short_n = 0;

    always @(posedge pclk) cyc_cnt <= cyc_cnt + 1;

    // Log every output event, sampled half a cycle away from the active edge
    always @(negedge pclk) begin
        if (bus.mem_we) begin
            wr_addr.push_back(int'(bus.mem_addr));
            wr_data.push_back(int'(bus.mem_data));
            wr_cyc.push_back(cyc_cnt);
            $display("write addr=%0d data=%0d cycle=%0d", bus.mem_addr, bus.mem_data, cyc_cnt);
        end
        if (bus.frame_ready) begin
            fr_bank.push_back(int'(bus.ready_bank));
            fr_cyc.push_back(cyc_cnt);
            $display("frame_ready bank=%0d cycle=%0d", bus.ready_bank, cyc_cnt);
        end
        if (bus.err_line)  err_line_n  = err_line_n + 1;
        if (bus.err_short) err_short_n = err_short_n + 1;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_checks = n_checks + 1;
        if (obs !== exp_v) begin
            n_fail = n_fail + 1;
            $display("FAIL %s: got %0d, expected %0d", tag, obs, exp_v);
        end else begin
            $display("ok   %s: %0d", tag, obs);
        end
    endtask

    task automatic tick();
        @(posedge pclk);
        #1;
    endtask

    task automatic send_px(input logic [15:0] d);
        bus.px_data  = d;
        bus.px_valid = 1'b1;
        tick();
        bus.px_valid = 1'b0;
    endtask

    task automatic end_line();
        bus.line_end = 1'b1;
        tick();
        bus.line_end = 1'b0;
    endtask

    task automatic start_frame();
        bus.frame_start = 1'b1;
        tick();
        bus.frame_start = 1'b0;
    endtask

    task automatic send_frame(input logic [15:0] d);
        start_frame();
        for (int l = 0; l < HEIGHT; l++) begin
            for (int p = 0; p < WIDTH; p++) send_px(d);
            end_line();
        end
        repeat (4) tick();
    endtask

    task automatic check_reset_outputs(input string pfx);
        check({pfx, "_mem_we"},      bus.mem_we,      0);
        check({pfx, "_mem_addr"},    bus.mem_addr,    0);
        check({pfx, "_mem_data"},    bus.mem_data,    0);
        check({pfx, "_frame_ready"}, bus.frame_ready, 0);
        check({pfx, "_ready_bank"},  bus.ready_bank,  0);
        check({pfx, "_bank_full"},   bus.bank_full,   0);
        check({pfx, "_err_line"},    bus.err_line,    0);
        check({pfx, "_err_short"},   bus.err_short,   0);
        check({pfx, "_drop_count"},  bus.drop_count,  0);
    endtask

    initial begin
        int wb, fb, el, es;
        int acc[4];
        logic [15:0] pix_v [4];
        int          gray_v[4];
        pix_v[0] = 16'hF800; gray_v[0] = 76;
        pix_v[1] = 16'h07E0; gray_v[1] = 149;
        pix_v[2] = 16'h001F; gray_v[2] = 28;
        pix_v[3] = 16'h0000; gray_v[3] = 0;

        bus.px_data      = '0;
        bus.px_valid     = 1'b0;
        bus.frame_start  = 1'b0;
        bus.line_end     = 1'b0;
        bus.buf_release  = 1'b0;
        bus.release_bank = 1'b0;

        // Reset state
        repeat (3) tick();
        check_reset_outputs("rst0");
        rst = 1'b0;
        tick();

        // Full white frame into bank 0
        wb = wr_addr.size(); fb = fr_bank.size(); el = err_line_n;
        send_frame(16'hFFFF);
        check("t1_nwrites", wr_addr.size() - wb, 8);
        for (int i = 0; i < 8; i++) begin
            if (wr_addr.size() > wb + i) begin
                check($sformatf("t1_addr%0d", i), wr_addr[wb + i], i);
                check($sformatf("t1_data%0d", i), wr_data[wb + i], 255);
            end
        end
        check("t1_nready", fr_bank.size() - fb, 1);
        if (fr_bank.size() > fb && wr_addr.size() >= wb + 8) begin
            check("t1_ready_bank", fr_bank[fb], 0);
            check("t1_ready_timing", fr_cyc[fb], wr_cyc[wb + 7] + 1);
        end
        check("t1_bank_full", bus.bank_full, 2'b01);
        check("t1_no_err_line", err_line_n - el, 0);

        // Release bank 0
        bus.buf_release = 1'b1; bus.release_bank = 1'b0;
        tick();
        bus.buf_release = 1'b0;
        check("rel_bank_full", bus.bank_full, 2'b00);

        // Primary colours, with 2-cycle latency, as frame 1 -> bank 0
        wb = wr_addr.size(); fb = fr_bank.size();
        start_frame();
        for (int i = 0; i < 4; i++) begin
            send_px(pix_v[i]);
            acc[i] = cyc_cnt;
        end
        end_line();
        for (int i = 0; i < 4; i++) send_px(16'h0000);
        end_line();
        repeat (4) tick();
        check("t2_nwrites", wr_addr.size() - wb, 8);
        for (int i = 0; i < 4; i++) begin
            if (wr_addr.size() > wb + i) begin
                check($sformatf("t2_data%0d", i), wr_data[wb + i], gray_v[i]);
                check($sformatf("t2_addr%0d", i), wr_addr[wb + i], i);
                check($sformatf("t2_lat%0d", i), wr_cyc[wb + i], acc[i] + 2);
            end
        end
        if (fr_bank.size() > fb) check("f1_ready_bank", fr_bank[fb], 0);
        check("f1_bank_full", bus.bank_full, 2'b01);

        // Frame 2 -> bank 1; 0x1234 -> (77*16+150*69+29*165)>>8 = 63
        wb = wr_addr.size(); fb = fr_bank.size();
        send_frame(16'h1234);
        check("f2_nwrites", wr_addr.size() - wb, 8);
        if (wr_addr.size() >= wb + 8) begin
            check("f2_first_addr", wr_addr[wb], BANK1);
            check("f2_last_addr", wr_addr[wb + 7], BANK1 + 7);
            check("f2_data", wr_data[wb], 63);
        end
        check("f2_nready", fr_bank.size() - fb, 1);
        if (fr_bank.size() > fb) check("f2_ready_bank", fr_bank[fb], 1);
        check("f2_bank_full", bus.bank_full, 2'b11);

        // Frame 3 -> dropped
        wb = wr_addr.size(); fb = fr_bank.size();
        send_frame(16'hFFFF);
        check("f3_nwrites", wr_addr.size() - wb, 0);
        check("f3_nready", fr_bank.size() - fb, 0);
        check("f3_drop_count", bus.drop_count, 1);

        // Release of bank 0 together with frame_start claims bank 0
        bus.frame_start = 1'b1; bus.buf_release = 1'b1; bus.release_bank = 1'b0;
        tick();
        bus.frame_start = 1'b0; bus.buf_release = 1'b0;
        check("t4_bank_full", bus.bank_full, 2'b10);
        check("t4_drop_count", bus.drop_count, 1);

        // Over-long line: 5 pixels on a 4-pixel line
        wb = wr_addr.size(); el = err_line_n;
        for (int i = 0; i < 5; i++) send_px(16'hFFFF);
        end_line();
        repeat (2) tick();
        check("t5_nwrites", wr_addr.size() - wb, 4);
        for (int i = 0; i < 4; i++)
            if (wr_addr.size() > wb + i) check($sformatf("t5_addr%0d", i), wr_addr[wb + i], i);
        check("t5_err_line", err_line_n - el, 1);

        // Short frame: restart on the same bank after 1 of 2 lines
        wb = wr_addr.size(); es = err_short_n; fb = fr_bank.size(); el = err_line_n;
        send_px(16'h0000);
        send_px(16'h0000);
        start_frame();
        send_px(16'hF800);
        repeat (3) tick();
        check("t6_nwrites", wr_addr.size() - wb, 3);
        if (wr_addr.size() >= wb + 3) begin
            check("t6_inflight_addr", wr_addr[wb + 1], 5);
            check("t6_restart_addr", wr_addr[wb + 2], 0);
            check("t6_restart_data", wr_data[wb + 2], 76);
        end
        check("t6_err_short", err_short_n - es, 1);
        check("t6_err_line", err_line_n - el, 0);
        check("t6_nready", fr_bank.size() - fb, 0);
        check("t6_bank_full", bus.bank_full, 2'b10);

        // Reset with a pixel in flight
        wb = wr_addr.size();
        send_px(16'hFFFF);
        rst = 1'b1;
        repeat (3) tick();
        check("t7_nwrites", wr_addr.size() - wb, 0);
        check_reset_outputs("rst1");
        rst = 1'b0;
        tick();

        // After reset the writer starts again at bank 0 base
        wb = wr_addr.size();
        start_frame();
        send_px(16'h07E0);
        repeat (3) tick();
        check("t8_nwrites", wr_addr.size() - wb, 1);
        if (wr_addr.size() > wb) begin
            check("t8_addr", wr_addr[wb], 0);
            check("t8_data", wr_data[wb], 149);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
